pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Arbitrates four event sources into one consistent set of pipeline-register and PC control signals:
  - load-use hazards (ID vs EX)
  - data-memory wait (MEM)
  - branch mispredict (EX)
  - ecall halt (ID)
- Owns the halt drain sequence and the stall/flush performance counters.
- Sits beside the datapath, driving PC and the IF/ID, ID/EX, EX/MEM and MEM/WB write/flush controls.

Parameters:
- DRAIN_CYCLES, 4, cycles after halt acceptance before is_halted asserts (lets older instructions retire); legal range 1..15.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- id_ex_mem_read  input  1  instruction in EX is a load
- id_ex_rd  input  5  destination register of the instruction in EX
- if_id_rs1  input  5  rs1 of the instruction in ID
- if_id_rs2  input  5  rs2 of the instruction in ID
- if_id_use_rs1  input  1  instruction in ID reads rs1
- if_id_use_rs2  input  1  instruction in ID reads rs2
- dmem_req  input  1  MEM stage has a valid load or store
- dmem_ready  input  1  data memory completes the access this cycle
- ex_mispredict  input  1  EX resolved a branch or jump to a different target than was fetched
- halt_req  input  1  ID holds ecall with x17==10
- pc_write  output  1  PC register update enable
- if_id_write  output  1  IF/ID write enable
- if_id_flush  output  1  IF/ID loaded with a bubble
- id_ex_flush  output  1  ID/EX loaded with a bubble
- ex_mem_write  output  1  EX/MEM write enable
- mem_wb_bubble  output  1  MEM/WB loaded with a bubble
- is_halted  output  1  pipeline fully drained after halt
- stall_count  output  CNT_W  cycles with pc_write==0 in RUN or MEM_WAIT
- flush_count  output  CNT_W  mispredict flushes taken

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Reset (async): state=RUN, drain counter=0, is_halted=0, both counters=0.
- Control outputs are combinational from state and inputs. Defaults: pc_write=1, if_id_write=1, ex_mem_write=1, all flush/bubble signals=0.
- Derived signals:
  - freeze = (state==MEM_WAIT) | (dmem_req & ~dmem_ready)
  - load_use = id_ex_mem_read & id_ex_rd!=0 & ((if_id_use_rs1 & rd==rs1) | (if_id_use_rs2 & rd==rs2))
- Priority within RUN (highest first):
  1. freeze: pc_write=0, if_id_write=0, ex_mem_write=0, mem_wb_bubble=1. All other events are ignored that cycle; they are re-evaluated after unfreeze.
  2. ex_mispredict: if_id_flush=1, id_ex_flush=1, pc_write=1 (the datapath selects the corrected target). flush_count+1. Overrides load_use and halt_req.
  3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble per stall cycle. Halt is not accepted in the same cycle.
  4. halt_req: accepted. Outputs this cycle: pc_write=0, if_id_flush=1. Next state=DRAIN, drain counter loaded with DRAIN_CYCLES-1.
- RUN -> MEM_WAIT when dmem_req & ~dmem_ready.
- MEM_WAIT:
  - Stays while ~dmem_ready, holding freeze outputs.
  - On dmem_ready: outputs are still frozen that cycle; next state=RUN.
  - A dmem_ready arriving in the same cycle as dmem_req in RUN means no stall.
- DRAIN:
  - pc_write=0, if_id_flush=1, id_ex_flush=1 every cycle, so no new instructions enter.
  - freeze is honoured exactly as in RUN and pauses the drain counter.
  - When not frozen, the counter decrements. At 0 and not frozen, next state=HALTED.
  - ex_mispredict and halt_req are ignored; no counters increment.
- HALTED:
  - is_halted=1 (registered).
  - pc_write=0, if_id_write=0, ex_mem_write=0, mem_wb_bubble=1, flushes=0.
  - Stays until reset.
- Counters:
  - stall_count increments every cycle pc_write==0 in RUN or MEM_WAIT.
  - Both counters saturate at all-ones; no wrap.
- Reset asserted in any state forces RUN immediately. Counters clear.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - state encoding as localparams: RUN=2'd0, MEM_WAIT=2'd1, DRAIN=2'd2, HALTED=2'd3
  - DRAIN counter width (4)
- Sub-module load_use_detector: combinational, computes load_use from the EX/ID register fields and use flags.
- The FSM, priority mux and counters stay in the top module.

Test Plan:
- Load x5 in EX, ID uses rs1=x5 -> exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1. Same case with rd=x0, or with if_id_use_rs1=0 -> no stall.
- dmem_req=1 with dmem_ready low for 3 cycles -> 4 frozen cycles: 3 waiting plus the ready cycle in MEM_WAIT. mem_wb_bubble=1 throughout; back to RUN; stall_count=4.
- ex_mispredict and load_use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count=1; stall_count unchanged.
- ex_mispredict while dmem stalled -> no flush until unfreeze; flush happens in the first RUN cycle where mispredict is still presented.
- halt_req with DRAIN_CYCLES=4 -> is_halted rises 5 cycles after acceptance. Repeat with a 2-cycle dmem stall during DRAIN -> rises 2 cycles later. halt_req together with mispredict -> halt ignored.
- Assert reset asynchronously mid-DRAIN -> state RUN, is_halted=0, counters 0 before the next clock edge. Force stall_count to all-ones -1 with 3 stall cycles -> holds at all-ones.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_DRAIN    = 2'd2;
   localparam logic [1:0] ST_HALTED   = 2'd3;

   typedef enum logic [1:0] {
      RUN      = ST_RUN,
      MEM_WAIT = ST_MEM_WAIT,
      DRAIN    = ST_DRAIN,
      HALTED   = ST_HALTED
   } state_t;

   localparam int DRAIN_CNT_W = 4;
   localparam int REG_W       = 5;

endpackage

// File: rtl/load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// Purely combinational; x0 never creates a hazard.
module load_use_detector
   import pipeline_ctrl_pkg::*;
(
   input  logic             id_ex_mem_read,
   input  logic [REG_W-1:0] id_ex_rd,
   input  logic [REG_W-1:0] if_id_rs1,
   input  logic [REG_W-1:0] if_id_rs2,
   input  logic             if_id_use_rs1,
   input  logic             if_id_use_rs2,
   output logic             load_use
);

   logic hit_rs1;
   logic hit_rs2;

   assign hit_rs1  = if_id_use_rs1 && (id_ex_rd == if_id_rs1);
   assign hit_rs2  = if_id_use_rs2 && (id_ex_rd == if_id_rs2);
   assign load_use = id_ex_mem_read && (id_ex_rd != '0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: controls are combinational from state and events, counters and is_halted are registered.
// Memory wait freezes the whole pipe; halt drains DRAIN_CYCLES cycles and then holds until reset.
module pipeline_stall_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rd,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic             if_id_use_rs1,
   input  logic             if_id_use_rs2,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             ex_mispredict,
   input  logic             halt_req,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_bubble,
   output logic             is_halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

   state_t                 state;
   state_t                 state_nxt;
   logic [DRAIN_CNT_W-1:0] drain_cnt;
   logic [DRAIN_CNT_W-1:0] drain_cnt_nxt;
   logic                   load_use;
   logic                   mem_stuck;
   logic                   freeze;
   logic                   count_stall;
   logic                   count_flush;

   load_use_detector u_load_use_detector (
      .id_ex_mem_read (id_ex_mem_read),
      .id_ex_rd       (id_ex_rd),
      .if_id_rs1      (if_id_rs1),
      .if_id_rs2      (if_id_rs2),
      .if_id_use_rs1  (if_id_use_rs1),
      .if_id_use_rs2  (if_id_use_rs2),
      .load_use       (load_use)
   );

   assign mem_stuck = dmem_req && !dmem_ready;
   assign freeze    = (state == MEM_WAIT) || mem_stuck;

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_write  = 1'b1;
      mem_wb_bubble = 1'b0;
      count_flush   = 1'b0;
      case (state)
         RUN, MEM_WAIT: begin
            if (freeze) begin
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               ex_mem_write  = 1'b0;
               mem_wb_bubble = 1'b1;
               // The ready cycle in MEM_WAIT stays frozen; only the state moves on.
               if (state == RUN)     state_nxt = MEM_WAIT;
               else if (dmem_ready)  state_nxt = RUN;
            end else if (ex_mispredict) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               count_flush = 1'b1;
            end else if (load_use) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
            end else if (halt_req) begin
               pc_write      = 1'b0;
               if_id_flush   = 1'b1;
               state_nxt     = DRAIN;
               drain_cnt_nxt = DRAIN_LOAD;
            end
         end
         DRAIN: begin
            if (freeze) begin
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               ex_mem_write  = 1'b0;
               mem_wb_bubble = 1'b1;
            end else begin
               pc_write    = 1'b0;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               if (drain_cnt == '0) state_nxt = HALTED;
               else                 drain_cnt_nxt = drain_cnt - DRAIN_CNT_W'(1);
            end
         end
         HALTED: begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign count_stall = ((state == RUN) || (state == MEM_WAIT)) && !pc_write;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         drain_cnt   <= '0;
         is_halted   <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         is_halted <= (state_nxt == HALTED);
         if (count_stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
         if (count_flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed vector table, async-reset and saturation sequences, then random traffic against a rule-level model.
module tb_pipeline_stall_controller;

   localparam int DRAIN   = 4;
   localparam int SMALL_W = 4;
   localparam int SMALL_MAX = (1 << SMALL_W) - 1;

   // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble}
   localparam logic [5:0] C_IDLE = 6'b110010;
   localparam logic [5:0] C_LU   = 6'b000110;
   localparam logic [5:0] C_FRZ  = 6'b000001;
   localparam logic [5:0] C_MIS  = 6'b111110;
   localparam logic [5:0] C_ACC  = 6'b011010;
   localparam logic [5:0] C_DRN  = 6'b011110;

   logic clk = 1'b0;
   logic reset;
   logic id_ex_mem_read;
   logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
   logic if_id_use_rs1, if_id_use_rs2, dmem_req, dmem_ready, ex_mispredict, halt_req;

   logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble, is_halted;
   logic [31:0] stall_count, flush_count;
   logic s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_write, s_mem_wb_bubble, s_is_halted;
   logic [SMALL_W-1:0] s_stall_count, s_flush_count;

   logic [5:0] ctrl, s_ctrl;
   assign ctrl   = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble};
   assign s_ctrl = {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_write, s_mem_wb_bubble};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_stall_controller #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .ex_mispredict(ex_mispredict), .halt_req(halt_req),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble), .is_halted(is_halted),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   pipeline_stall_controller #(.DRAIN_CYCLES(DRAIN), .CNT_W(SMALL_W)) dut_small (
      .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .ex_mispredict(ex_mispredict), .halt_req(halt_req),
      .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
      .ex_mem_write(s_ex_mem_write), .mem_wb_bubble(s_mem_wb_bubble), .is_halted(s_is_halted),
      .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   typedef struct {
      logic       mr;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, req, rdy, mis, halt;
      logic [5:0] c;
      logic       h;
      int         s, f;
   } vec_t;

   function automatic vec_t mk(logic mr, int rd, int rs1, int rs2, logic u1, logic u2, logic req, logic rdy,
                               logic mis, logic halt, logic [5:0] c, logic h, int s, int f);
      vec_t v;
      v.mr = mr; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
      v.req = req; v.rdy = rdy; v.mis = mis; v.halt = halt; v.c = c; v.h = h; v.s = s; v.f = f;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic idle();
      id_ex_mem_read = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0; if_id_use_rs1 = 0; if_id_use_rs2 = 0;
      dmem_req = 0; dmem_ready = 0; ex_mispredict = 0; halt_req = 0;
   endtask

   task automatic drive(input vec_t v);
      id_ex_mem_read = v.mr; id_ex_rd = v.rd; if_id_rs1 = v.rs1; if_id_rs2 = v.rs2;
      if_id_use_rs1 = v.u1; if_id_use_rs2 = v.u2; dmem_req = v.req; dmem_ready = v.rdy;
      ex_mispredict = v.mis; halt_req = v.halt;
   endtask

   // Reference model: pipeline condition expressed as flags and a remaining-drain count.
   bit m_wait, m_drain, m_halted;
   int m_left, m_stall, m_flush;

   task automatic model_reset();
      m_wait = 0; m_drain = 0; m_halted = 0; m_left = 0; m_stall = 0; m_flush = 0;
   endtask

   function automatic logic [5:0] expect_ctrl();
      bit lu, stuck;
      lu = id_ex_mem_read && (id_ex_rd != 0) &&
           ((if_id_use_rs1 && id_ex_rd == if_id_rs1) || (if_id_use_rs2 && id_ex_rd == if_id_rs2));
      stuck = dmem_req && !dmem_ready;
      if (m_halted)          return C_FRZ;
      if (m_wait || stuck)   return C_FRZ;
      if (m_drain)           return C_DRN;
      if (ex_mispredict)     return C_MIS;
      if (lu)                return C_LU;
      if (halt_req)          return C_ACC;
      return C_IDLE;
   endfunction

   task automatic model_advance(input logic [5:0] c);
      bit running;
      running = !m_halted && !m_drain;
      if (running && !c[5]) m_stall++;
      if (running && c == C_MIS) m_flush++;
      if (m_halted) begin
      end else if (m_drain) begin
         if (c != C_FRZ) begin
            if (m_left == 0) begin m_drain = 0; m_halted = 1; end
            else m_left--;
         end
      end else if (m_wait) begin
         if (dmem_ready) m_wait = 0;
      end else if (c == C_FRZ) begin
         m_wait = 1;
      end else if (c == C_ACC) begin
         m_drain = 1; m_left = DRAIN - 1;
      end
   endtask

   function automatic int sat(int v);
      return (v > SMALL_MAX) ? SMALL_MAX : v;
   endfunction

   vec_t tbl[30];

   initial begin
      tbl[0]  = mk(0,0,0,0, 0,0, 0,0, 0,0, C_IDLE,0, 0,0);
      tbl[1]  = mk(1,5,5,0, 1,0, 0,0, 0,0, C_LU,  0, 0,0);
      tbl[2]  = mk(0,5,5,0, 1,0, 0,0, 0,0, C_IDLE,0, 1,0);
      tbl[3]  = mk(1,0,0,0, 1,0, 0,0, 0,0, C_IDLE,0, 1,0);
      tbl[4]  = mk(1,5,5,6, 0,1, 0,0, 0,0, C_IDLE,0, 1,0);
      tbl[5]  = mk(1,7,3,7, 1,1, 0,0, 0,0, C_LU,  0, 1,0);
      tbl[6]  = mk(0,0,0,0, 0,0, 1,0, 0,0, C_FRZ, 0, 2,0);
      tbl[7]  = mk(0,0,0,0, 0,0, 1,0, 0,0, C_FRZ, 0, 3,0);
      tbl[8]  = mk(0,0,0,0, 0,0, 1,0, 0,0, C_FRZ, 0, 4,0);
      tbl[9]  = mk(0,0,0,0, 0,0, 1,1, 0,0, C_FRZ, 0, 5,0);
      tbl[10] = mk(0,0,0,0, 0,0, 0,0, 0,0, C_IDLE,0, 6,0);
      tbl[11] = mk(0,0,0,0, 0,0, 1,1, 0,0, C_IDLE,0, 6,0);
      tbl[12] = mk(1,5,5,0, 1,0, 0,0, 1,0, C_MIS, 0, 6,0);
      tbl[13] = mk(0,0,0,0, 0,0, 0,0, 0,0, C_IDLE,0, 6,1);
      tbl[14] = mk(0,0,0,0, 0,0, 1,0, 1,0, C_FRZ, 0, 6,1);
      tbl[15] = mk(0,0,0,0, 0,0, 1,1, 1,0, C_FRZ, 0, 7,1);
      tbl[16] = mk(0,0,0,0, 0,0, 0,0, 1,0, C_MIS, 0, 8,1);
      tbl[17] = mk(0,0,0,0, 0,0, 0,0, 0,0, C_IDLE,0, 8,2);
      tbl[18] = mk(0,0,0,0, 0,0, 0,0, 1,1, C_MIS, 0, 8,2);
      tbl[19] = mk(0,0,0,0, 0,0, 0,0, 0,0, C_IDLE,0, 8,3);
      tbl[20] = mk(1,5,5,0, 1,0, 0,0, 0,1, C_LU,  0, 8,3);
      tbl[21] = mk(0,0,0,0, 0,0, 0,0, 0,1, C_ACC, 0, 9,3);
      tbl[22] = mk(0,0,0,0, 0,0, 0,0, 1,0, C_DRN, 0, 10,3);
      tbl[23] = mk(0,0,0,0, 0,0, 0,0, 0,0, C_DRN, 0, 10,3);
      tbl[24] = mk(0,0,0,0, 0,0, 1,0, 0,0, C_FRZ, 0, 10,3);
      tbl[25] = mk(0,0,0,0, 0,0, 1,0, 0,0, C_FRZ, 0, 10,3);
      tbl[26] = mk(0,0,0,0, 0,0, 1,1, 0,0, C_DRN, 0, 10,3);
      tbl[27] = mk(0,0,0,0, 0,0, 0,0, 0,0, C_DRN, 0, 10,3);
      tbl[28] = mk(0,0,0,0, 0,0, 0,0, 0,0, C_FRZ, 1, 10,3);
      tbl[29] = mk(0,0,0,0, 0,0, 0,0, 1,1, C_FRZ, 1, 10,3);

      reset = 1'b1;
      idle();
      #1;
      check("reset ctrl", 32'(ctrl), 32'(C_IDLE));
      check("reset is_halted", 32'(is_halted), 0);
      check("reset stall_count", stall_count, 0);
      check("reset flush_count", flush_count, 0);

      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i > 0) @(negedge clk);
         drive(tbl[i]);
         #1;
         check($sformatf("row%0d ctrl", i), 32'(ctrl), 32'(tbl[i].c));
         check($sformatf("row%0d is_halted", i), 32'(is_halted), 32'(tbl[i].h));
         check($sformatf("row%0d stall_count", i), stall_count, tbl[i].s);
         check($sformatf("row%0d flush_count", i), flush_count, tbl[i].f);
         check($sformatf("row%0d small ctrl", i), 32'(s_ctrl), 32'(tbl[i].c));
      end

      // Asynchronous reset while HALTED, between clock edges.
      @(negedge clk);
      idle();
      #2 reset = 1'b1;
      #1;
      check("async rst halted is_halted", 32'(is_halted), 0);
      check("async rst halted stall_count", stall_count, 0);
      check("async rst halted flush_count", flush_count, 0);
      check("async rst halted ctrl", 32'(ctrl), 32'(C_IDLE));

      // Asynchronous reset in the middle of DRAIN.
      @(negedge clk);
      reset = 1'b0;
      halt_req = 1'b1;
      #1 check("drain accept ctrl", 32'(ctrl), 32'(C_ACC));
      @(negedge clk);
      halt_req = 1'b0;
      #1;
      check("drain ctrl", 32'(ctrl), 32'(C_DRN));
      check("drain stall_count", stall_count, 1);
      #1 reset = 1'b1;
      #1;
      check("async rst drain ctrl", 32'(ctrl), 32'(C_IDLE));
      check("async rst drain stall_count", stall_count, 0);
      check("async rst drain small stall", 32'(s_stall_count), 0);
      @(negedge clk);
      reset = 1'b0;

      // Saturation: 18 load-use stalls then 17 mispredicts.
      for (int k = 0; k < 18; k++) begin
         if (k > 0) @(negedge clk);
         drive(mk(1,9,9,0, 1,0, 0,0, 0,0, C_LU,0,0,0));
         #1 check($sformatf("sat lu%0d ctrl", k), 32'(ctrl), 32'(C_LU));
      end
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         drive(mk(0,0,0,0, 0,0, 0,0, 1,0, C_MIS,0,0,0));
         #1 if (k == 0) check("sat small stall", 32'(s_stall_count), SMALL_MAX);
      end
      @(negedge clk);
      idle();
      #1;
      check("sat big stall", stall_count, 18);
      check("sat small stall hold", 32'(s_stall_count), SMALL_MAX);
      check("sat big flush", flush_count, 17);
      check("sat small flush", 32'(s_flush_count), SMALL_MAX);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] e;
         @(negedge clk);
         reset          = (i == 0) || ($urandom_range(0, 79) == 0);
         id_ex_mem_read = 1'($urandom_range(0, 1));
         id_ex_rd       = 5'($urandom_range(0, 3));
         if_id_rs1      = 5'($urandom_range(0, 3));
         if_id_rs2      = 5'($urandom_range(0, 3));
         if_id_use_rs1  = 1'($urandom_range(0, 1));
         if_id_use_rs2  = 1'($urandom_range(0, 1));
         dmem_req       = ($urandom_range(0, 2) == 0);
         dmem_ready     = 1'($urandom_range(0, 1));
         ex_mispredict  = ($urandom_range(0, 5) == 0);
         halt_req       = ($urandom_range(0, 49) == 0);
         if (reset) model_reset();
         e = expect_ctrl();
         #1;
         check("rnd ctrl", 32'(ctrl), 32'(e));
         check("rnd is_halted", 32'(is_halted), 32'(m_halted));
         check("rnd stall_count", stall_count, m_stall);
         check("rnd flush_count", flush_count, m_flush);
         check("rnd small ctrl", 32'(s_ctrl), 32'(e));
         check("rnd small stall", 32'(s_stall_count), sat(m_stall));
         check("rnd small flush", 32'(s_flush_count), sat(m_flush));
         @(posedge clk);
         if (!reset) model_advance(e);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
